// File: rtl/iopmp_error_capture_ctrl.sv
// Captures IOPMP violation reports from all checker channels into one shared error record.
// Per-channel one-entry pending buffers are drained round-robin; the record stays locked until software clears it.
module iopmp_error_capture_ctrl #(
    parameter  int unsigned IOPMPNumChan = 2,
    parameter  int unsigned AddrWidth    = 64,
    parameter  int unsigned IdWidth      = 16,
    parameter  int unsigned DropCntWidth = 8,
    localparam int unsigned ChanW        = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [IOPMPNumChan-1:0]                  err_valid_i,
    input  logic [IOPMPNumChan-1:0][1:0]             err_ttype_i,
    input  logic [IOPMPNumChan-1:0][2:0]             err_etype_i,
    input  logic [IOPMPNumChan-1:0][AddrWidth-1:0]   err_addr_i,
    input  logic [IOPMPNumChan-1:0][IdWidth-1:0]     err_id_i,
    input  logic                                     sw_clear_i,
    input  logic                                     err_ie_i,
    output logic                                     rec_v_o,
    output logic [1:0]                               rec_ttype_o,
    output logic [2:0]                               rec_etype_o,
    output logic [31:0]                              rec_addr_o,
    output logic [AddrWidth-33:0]                    rec_addrh_o,
    output logic [IdWidth-1:0]                       rec_id_o,
    output logic [ChanW-1:0]                         rec_chan_o,
    output logic                                     err_wr_en_o,
    output logic                                     irq_o,
    output logic [IOPMPNumChan-1:0]                  pend_o,
    output logic [DropCntWidth-1:0]                  drop_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                                   state_q;
    logic [IOPMPNumChan-1:0]                  pend_q;
    logic [IOPMPNumChan-1:0][1:0]             ent_ttype_q;
    logic [IOPMPNumChan-1:0][2:0]             ent_etype_q;
    logic [IOPMPNumChan-1:0][AddrWidth-1:0]   ent_addr_q;
    logic [IOPMPNumChan-1:0][IdWidth-1:0]     ent_id_q;
    logic [ChanW-1:0]                         last_grant_q;
    logic [DropCntWidth-1:0]                  drop_cnt_q;
    logic [DropCntWidth-1:0]                  drop_cnt_d;
    logic                                     rec_v_q;
    logic [1:0]                               rec_ttype_q;
    logic [2:0]                               rec_etype_q;
    logic [AddrWidth-1:0]                     rec_addr_q;
    logic [IdWidth-1:0]                       rec_id_q;
    logic [ChanW-1:0]                         rec_chan_q;
    logic                                     wr_en_q;

    logic                                     grant_valid_s;
    logic [ChanW-1:0]                         grant_idx_s;
    logic [ChanW-1:0]                         cand_s;
    logic [IOPMPNumChan-1:0]                  grant_vec_s;
    logic [IOPMPNumChan-1:0]                  accept_s;
    logic [IOPMPNumChan-1:0]                  drop_s;
    logic [DropCntWidth+4:0]                  drop_sum_s;

    // Round-robin pick: scan from farthest to nearest after last_grant so the nearest set bit wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        if (state_q == ST_IDLE) begin
            for (int k = int'(IOPMPNumChan); k >= 1; k--) begin
                cand_s = ChanW'((int'(last_grant_q) + k) % int'(IOPMPNumChan));
                if (pend_q[cand_s]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = cand_s;
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // Per-channel acceptance; a buffer being drained this cycle can take a new report.
    always_comb begin
        grant_vec_s = '0;
        accept_s    = '0;
        drop_s      = '0;
        for (int i = 0; i < int'(IOPMPNumChan); i++) begin
            grant_vec_s[i] = grant_valid_s && (grant_idx_s == ChanW'(i));
            accept_s[i]    = err_valid_i[i] && (err_ttype_i[i] != 2'b00);
            drop_s[i]      = accept_s[i] && pend_q[i] && !grant_vec_s[i];
        end
    end

    // Saturating drop counter accumulation across all channels.
    always_comb begin
        drop_sum_s = {5'b00000, drop_cnt_q};
        for (int i = 0; i < int'(IOPMPNumChan); i++) begin
            drop_sum_s = drop_sum_s + {{(DropCntWidth+4){1'b0}}, drop_s[i]};
        end
        if (drop_sum_s > {5'b00000, {DropCntWidth{1'b1}}}) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum_s[DropCntWidth-1:0];
        end
    end

    // Pending buffers and drop counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q      <= '0;
            ent_ttype_q <= '0;
            ent_etype_q <= '0;
            ent_addr_q  <= '0;
            ent_id_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < int'(IOPMPNumChan); i++) begin
                if (accept_s[i] && !drop_s[i]) begin
                    pend_q[i]      <= 1'b1;
                    ent_ttype_q[i] <= err_ttype_i[i];
                    ent_etype_q[i] <= err_etype_i[i];
                    ent_addr_q[i]  <= err_addr_i[i];
                    ent_id_q[i]    <= err_id_i[i];
                end else if (grant_vec_s[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record FSM: capture the granted entry in IDLE, hold it until software clears.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            rec_v_q      <= 1'b0;
            rec_ttype_q  <= '0;
            rec_etype_q  <= '0;
            rec_addr_q   <= '0;
            rec_id_q     <= '0;
            rec_chan_q   <= '0;
            wr_en_q      <= 1'b0;
            last_grant_q <= ChanW'(IOPMPNumChan - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        rec_ttype_q  <= ent_ttype_q[grant_idx_s];
                        rec_etype_q  <= ent_etype_q[grant_idx_s];
                        rec_addr_q   <= ent_addr_q[grant_idx_s];
                        rec_id_q     <= ent_id_q[grant_idx_s];
                        rec_chan_q   <= grant_idx_s;
                        rec_v_q      <= 1'b1;
                        wr_en_q      <= 1'b1;
                        last_grant_q <= grant_idx_s;
                        state_q      <= ST_HOLD;
                    end else begin
                        wr_en_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    wr_en_q <= 1'b0;
                    if (sw_clear_i) begin
                        rec_v_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    rec_v_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rec_v_o     = rec_v_q;
    assign rec_ttype_o = rec_ttype_q;
    assign rec_etype_o = rec_etype_q;
    assign rec_addr_o  = rec_addr_q[31:0];
    assign rec_addrh_o = rec_addr_q[AddrWidth-1:32];
    assign rec_id_o    = rec_id_q;
    assign rec_chan_o  = rec_chan_q;
    assign err_wr_en_o = wr_en_q;
    assign irq_o       = rec_v_q & err_ie_i;
    assign pend_o      = pend_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule
